// File: rtl/math_arbiter.sv
// math_arbiter
// Shares one WIDTH-bit add/subtract datapath between two requesters.
// A round-robin arbiter grants one requester in IDLE, its operands are
// captured, the operation runs in EXEC, and DONE returns to IDLE, giving
// one operation every three cycles.
//
// Ports
//   i_clock            system clock, rising edge
//   i_reset_n          asynchronous active-low reset
//   i_req0/i_req1      level requests, sampled only in IDLE
//   i_op0/i_op1        0 = A+B, 1 = A-B
//   i_a0,i_b0/i_a1,i_b1  operands per requester
//   o_gnt0/o_gnt1      one-cycle pulse: operands captured
//   o_done0/o_done1    one-cycle pulse: result valid for that requester
//   o_result           last result, held until the next computation
//   o_carry            add: carry-out; sub: 1 = no borrow (A >= B)
//   o_zero             result == 0
//   o_busy             high in EXEC and DONE
module math_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic             i_op0,
  input  logic             i_op1,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_done0,
  output logic             o_done1,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_grant, w_sel;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_op, r_owner;
  logic             r_prio;   // requester favoured on a tie
  logic             r_gnt0, r_gnt1, r_done0, r_done1, r_busy;
  logic [WIDTH-1:0] r_result;
  logic             r_carry, r_zero;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_sel       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req0 | i_req1) begin
          w_grant     = 1'b1;
          // a lone request wins outright; a tie goes to the pointer
          w_sel       = (i_req0 & i_req1) ? r_prio : i_req1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Subtraction as A + ~B + 1 so the carry-out reads as "no borrow".
  assign w_b_eff = r_op ? ~r_b : r_b;
  assign w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_op};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_owner  <= 1'b0;
      r_prio   <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt0  <= w_grant & ~w_sel;
      r_gnt1  <= w_grant &  w_sel;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_grant) begin
        r_a     <= w_sel ? i_a1  : i_a0;
        r_b     <= w_sel ? i_b1  : i_b0;
        r_op    <= w_sel ? i_op1 : i_op0;
        r_owner <= w_sel;
        r_prio  <= ~w_sel;
      end
      r_done0 <= (r_state == S_EXEC) & ~r_owner;
      r_done1 <= (r_state == S_EXEC) &  r_owner;
      if (r_state == S_EXEC) begin
        r_result <= w_sum[WIDTH-1:0];
        r_carry  <= w_sum[WIDTH];
        r_zero   <= (w_sum[WIDTH-1:0] == '0);
      end
    end
  end

  assign o_gnt0   = r_gnt0;
  assign o_gnt1   = r_gnt1;
  assign o_done0  = r_done0;
  assign o_done1  = r_done1;
  assign o_result = r_result;
  assign o_carry  = r_carry;
  assign o_zero   = r_zero;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_math_arbiter.sv
// Self-checking bench for math_arbiter (WIDTH=4) against a behavioural
// model: last-granted arbitration and plain integer add/subtract.
module tb_math_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1, op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, carry, zero, busy;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;
  int m_last = -1;  // requester granted most recently, -1 after reset

  typedef struct packed {
    int gw; int gc; int gn; int dw; int dc; int dn; int bc;
    logic [W-1:0] r; logic c; logic z;
  } rec_t;

  math_arbiter #(.WIDTH(W)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_op0(op0), .i_op1(op1),
    .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_result(result), .o_carry(carry), .o_zero(zero), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) return (m_last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  // Expected outcome of the operation that the next IDLE edge will start.
  task automatic expect_op(output rec_t e);
    int who, av, bv, s;
    logic o;
    who = pick(req0, req1);
    av  = (who == 1) ? int'(a1) : int'(a0);
    bv  = (who == 1) ? int'(b1) : int'(b0);
    o   = (who == 1) ? op1 : op0;
    if (o) begin
      s   = (av - bv + 16) % 16;
      e.c = (av >= bv);
    end else begin
      s   = (av + bv) % 16;
      e.c = (av + bv) > 15;
    end
    e.r  = W'(s);
    e.z  = (s == 0);
    e.gw = who; e.gc = 1; e.gn = 1;
    e.dw = who; e.dc = 2; e.dn = 1; e.bc = 2;
    m_last = who;
  endtask

  // Runs three cycles from an IDLE sampling edge and records what happened.
  task automatic run_op(input bit drop, input bit scramble, output rec_t o);
    o = '0; o.gw = -1; o.dw = -1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (busy) o.bc++;
      if (gnt0 || gnt1) begin
        o.gn += int'(gnt0) + int'(gnt1);
        o.gw = gnt1 ? 1 : 0;
        o.gc = c;
        if (scramble) begin
          if (gnt1) begin a1 = W'($urandom); b1 = W'($urandom); op1 = 1'($urandom); end
          else      begin a0 = W'($urandom); b0 = W'($urandom); op0 = 1'($urandom); end
        end
        if (drop) begin
          if (gnt1) req1 = 1'b0; else req0 = 1'b0;
        end
      end
      if (done0 || done1) begin
        o.dn += int'(done0) + int'(done1);
        o.dw = done1 ? 1 : 0;
        o.dc = c;
        o.r = result; o.c = carry; o.z = zero;
      end
    end
  endtask

  task automatic test_reset();
    rec_t e, o;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    op0 = 1'b0; op1 = 1'b1; a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd1;
    tick(); tick();
    total++;
    if ({gnt0, gnt1, done0, done1, busy, carry, zero, result} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %b required all zero",
               {gnt0, gnt1, done0, done1, busy, carry, zero, result});
    end
    rst_n = 1'b1; m_last = -1;
    expect_op(e);
    run_op(1'b0, 1'b0, o);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL reset_first_grant: got gw=%0d gc=%0d r=%h required gw=%0d gc=%0d r=%h",
               o.gw, o.gc, o.r, e.gw, e.gc, e.r);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_add();
    rec_t e, o;
    logic [W-1:0] ta [2] = '{4'd7, 4'd9};
    logic [W-1:0] tb [2] = '{4'd5, 4'd8};
    for (int i = 0; i < 8; i++) begin
      req0 = 1'b1; op0 = 1'b0;
      if (i < 2) begin a0 = ta[i]; b0 = tb[i]; end
      else begin a0 = W'($urandom); b0 = W'($urandom); end
      expect_op(e);
      run_op(1'b1, i >= 2, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL add_%0d: got gw=%0d gc=%0d dw=%0d dc=%0d bc=%0d r=%h c=%b z=%b required gw=%0d gc=%0d dw=%0d dc=%0d bc=%0d r=%h c=%b z=%b",
                 i, o.gw, o.gc, o.dw, o.dc, o.bc, o.r, o.c, o.z, e.gw, e.gc, e.dw, e.dc, e.bc, e.r, e.c, e.z);
      end
    end
  endtask

  task automatic test_sub();
    rec_t e, o;
    logic [W-1:0] ta [3] = '{4'd3, 4'd6, 4'd9};
    logic [W-1:0] tb [3] = '{4'd5, 4'd6, 4'd4};
    for (int i = 0; i < 8; i++) begin
      req1 = 1'b1; op1 = 1'b1;
      if (i < 3) begin a1 = ta[i]; b1 = tb[i]; end
      else begin a1 = W'($urandom); b1 = W'($urandom); end
      expect_op(e);
      // operands are changed right after gnt1; the result must not move
      run_op(1'b1, 1'b1, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL sub_%0d: got gw=%0d dw=%0d r=%h c=%b z=%b required gw=%0d dw=%0d r=%h c=%b z=%b",
                 i, o.gw, o.dw, o.r, o.c, o.z, e.gw, e.dw, e.r, e.c, e.z);
      end
    end
    tick();
    total++;
    if ({result, carry, zero} !== {e.r, e.c, e.z}) begin
      bad++;
      $display("FAIL sub_hold: got r=%h c=%b z=%b required r=%h c=%b z=%b",
               result, carry, zero, e.r, e.c, e.z);
    end
  endtask

  task automatic test_arbitration();
    rec_t e, o;
    int order [4] = '{0, 1, 0, 1};
    rst_n = 1'b0; tick(); rst_n = 1'b1; m_last = -1;
    req0 = 1'b1; req1 = 1'b1; op0 = 1'b0; op1 = 1'b0;
    a0 = 4'd1; b0 = 4'd1; a1 = 4'd2; b1 = 4'd2;
    for (int i = 0; i < 4; i++) begin
      expect_op(e);
      run_op(1'b0, 1'b0, o);
      total++;
      if (o !== e || o.gw != order[i]) begin
        bad++;
        $display("FAIL arb_tie_%0d: got gw=%0d gn=%0d r=%h required gw=%0d r=%h",
                 i, o.gw, o.gn, o.r, order[i], e.r);
      end
    end
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req0 = 1'b1;  // tie after req1-only run must go to 0
      expect_op(e);
      run_op(1'b0, 1'b0, o);
      total++;
      if (o !== e || (i < 3 && o.gw != 1) || (i == 3 && o.gw != 0)) begin
        bad++;
        $display("FAIL arb_req1_%0d: got gw=%0d gc=%0d required gw=%0d gc=%0d",
                 i, o.gw, o.gc, e.gw, e.gc);
      end
    end
    for (int i = 0; i < 10; i++) begin
      int p;
      p = $urandom_range(3, 1);
      req0 = p[0]; req1 = p[1];
      a0 = W'($urandom); b0 = W'($urandom); op0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); op1 = 1'($urandom);
      expect_op(e);
      run_op(1'b1, 1'b1, o);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL arb_rand_%0d: got gw=%0d gn=%0d dw=%0d dn=%0d r=%h c=%b z=%b required gw=%0d dw=%0d r=%h c=%b z=%b",
                 i, o.gw, o.gn, o.dw, o.dn, o.r, o.c, o.z, e.gw, e.dw, e.r, e.c, e.z);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_mid_reset();
    rec_t e, o;
    req0 = 1'b1; op0 = 1'b0; a0 = 4'd5; b0 = 4'd6;
    expect_op(e);
    run_op(1'b1, 1'b0, o);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL midrst_pre: got r=%h required r=%h", o.r, e.r);
    end
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd4;
    tick();
    total++;
    if (gnt0 !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_gnt: got gnt0=%b busy=%b required gnt0=1 busy=1", gnt0, busy);
    end
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({gnt0, gnt1, done0, done1, busy, carry, zero, result} !== '0) begin
      bad++;
      $display("FAIL midrst_async: got %b required all zero",
               {gnt0, gnt1, done0, done1, busy, carry, zero, result});
    end
    tick();
    total++;
    if ({done0, done1, busy, result} !== '0) begin
      bad++;
      $display("FAIL midrst_nodone: got done0=%b done1=%b busy=%b r=%h required all zero",
               done0, done1, busy, result);
    end
    rst_n = 1'b1; m_last = -1;
    req0 = 1'b1; op0 = 1'b0; a0 = 4'd2; b0 = 4'd2;
    expect_op(e);
    run_op(1'b1, 1'b0, o);
    total++;
    if (o !== e || o.r !== 4'd4) begin
      bad++;
      $display("FAIL midrst_after: got gw=%0d r=%h required gw=0 r=4", o.gw, o.r);
    end
  endtask

  task automatic test_busy();
    rec_t e;
    req0 = 1'b1; op0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom);
    req1 = 1'b0;
    expect_op(e);
    tick();
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_gnt0: got gnt0=%b gnt1=%b busy=%b required 1 0 1", gnt0, gnt1, busy);
    end
    req0 = 1'b0; req1 = 1'b1; op1 = 1'b0; a1 = 4'd4; b1 = 4'd3;
    tick();
    total++;
    if (gnt1 !== 1'b0 || done0 !== 1'b1 || busy !== 1'b1 || result !== e.r) begin
      bad++;
      $display("FAIL busy_exec: got gnt1=%b done0=%b busy=%b r=%h required 0 1 1 r=%h",
               gnt1, done0, busy, result, e.r);
    end
    tick();
    total++;
    if (gnt1 !== 1'b0 || busy !== 1'b0 || done0 !== 1'b0) begin
      bad++;
      $display("FAIL busy_done: got gnt1=%b busy=%b done0=%b required 0 0 0", gnt1, busy, done0);
    end
    expect_op(e);
    tick();
    total++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_gnt1: got gnt1=%b gnt0=%b busy=%b required 1 0 1", gnt1, gnt0, busy);
    end
    req1 = 1'b0;
    tick();
    total++;
    if (done1 !== 1'b1 || result !== e.r || carry !== e.c) begin
      bad++;
      $display("FAIL busy_done1: got done1=%b r=%h c=%b required 1 r=%h c=%b",
               done1, result, carry, e.r, e.c);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_arbitration();
    test_mid_reset();
    test_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
